// File: rtl/mc_controller_if.sv
// Control bus between the multicycle ARM controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_controller_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite;
    logic         IRWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic         AdrSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ImmSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [2:0]   ALUControl;
    logic         MOVFlag;
    logic [1:0]   ResultSrc;
    logic         Undef;
    logic [3:0]   Flags;
    logic [3:0]   State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, MOVFlag, ResultSrc, Undef,
               Flags, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, MOVFlag, ResultSrc, Undef,
               Flags, State
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore FSM, data-processing decode,
// NZCV flag register and condition check for a shared-memory datapath.
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t state, state_next;

    logic [1:0] op;
    logic [3:0] cmd;
    logic [3:0] cond;
    logic       s_bit;
    logic       funct5;
    logic       rd_pc;
    logic [3:0] flags;
    logic       unused_rn;

    assign op        = bus.Instr[27:26];
    assign funct5    = bus.Instr[25];
    assign cmd       = bus.Instr[24:21];
    assign s_bit     = bus.Instr[20];
    assign cond      = bus.Instr[31:28];
    assign rd_pc     = (bus.Instr[15:12] == 4'hF);
    assign unused_rn = ^bus.Instr[19:16];

    // Data-processing decode.
    logic [2:0] dp_ctl;
    logic       dp_mov, dp_nowb, dp_cv, dp_undef;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dp_ctl   = 3'b000;
        dp_mov   = 1'b0;
        dp_nowb  = 1'b0;
        dp_cv    = 1'b0;
        dp_undef = 1'b0;
        case (cmd)
            4'b0100: dp_cv = 1'b1;
            4'b0010: begin dp_ctl = 3'b001; dp_cv = 1'b1; end
            4'b0000: dp_ctl = 3'b010;
            4'b1100: dp_ctl = 3'b011;
            4'b0001: dp_ctl = 3'b100;
            4'b1010: begin dp_ctl = 3'b001; dp_nowb = 1'b1; dp_cv = 1'b1; end
            4'b1000: begin dp_ctl = 3'b010; dp_nowb = 1'b1; end
            4'b1101: dp_mov = 1'b1;
            default: dp_undef = 1'b1;
        endcase
    end

    logic n_f, z_f, c_f, v_f, cond_ex;
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // NOTE: state and flag registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if ((state == EXECUTER || state == EXECUTEI) && (s_bit || dp_nowb)) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (dp_cv) flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

    logic       pc_write, ir_write, reg_write, mem_write, undef;
    logic       adr_src, alu_src_a, mov_flag;
    logic [1:0] alu_src_b, result_src;
    logic [2:0] alu_control;

    always_comb begin
        state_next  = FETCH;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        undef       = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 3'b000;
        mov_flag    = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (op == 2'b11 || (op == 2'b00 && dp_undef)) begin
                    undef = 1'b1;
                end else if (cond_ex && cond != 4'b1111) begin
                    case (op)
                        2'b01:   state_next = MEMADR;
                        2'b00:   state_next = funct5 ? EXECUTEI : EXECUTER;
                        default: state_next = BRANCH;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_b  = 2'b01;
                state_next = s_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                pc_write   = rd_pc;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER, EXECUTEI: begin
                alu_src_b   = (state == EXECUTEI) ? 2'b01 : 2'b00;
                alu_control = dp_ctl;
                mov_flag    = dp_mov;
                state_next  = ALUWB;
            end
            ALUWB: begin
                reg_write = ~dp_nowb;
                pc_write  = ~dp_nowb & rd_pc;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Write enables are held off for the whole reset interval, not just the edge.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.Undef      = undef     & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.MOVFlag    = mov_flag;
    assign bus.RegSrc     = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
    assign bus.ImmSrc     = (op == 2'b11) ? 2'b00 : op;
    assign bus.Flags      = flags;
    assign bus.State      = state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expectations are queued
// with their stimulus and compared as the FSM steps through each instruction.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       pcw, irw, regw, memw, adrsrc, alusrca;
        logic [1:0] alusrcb, resultsrc;
        logic [2:0] aluctl;
        logic       mov, undef;
        logic [3:0] flags;
        logic [1:0] regsrc, immsrc;
    } obs_t;

    typedef struct packed {
        logic [19:0] instr;
        logic [3:0]  aluflags;
        obs_t        v;
        obs_t        care;
    } exp_t;

    localparam logic [19:0] I_ADD  = 20'hE0812;
    localparam logic [19:0] I_SUBS = 20'hE2500;
    localparam logic [19:0] I_BEQ  = 20'h0A000;
    localparam logic [19:0] I_BNE  = 20'h1A000;
    localparam logic [19:0] I_BLT  = 20'hBA000;
    localparam logic [19:0] I_LDR  = 20'hE591F;
    localparam logic [19:0] I_STR  = 20'hE5812;
    localparam logic [19:0] I_MOVS = 20'hE3B01;
    localparam logic [19:0] I_CMP  = 20'hE3500;
    localparam logic [19:0] I_UND  = 20'hEC000;
    localparam logic [19:0] I_RSB  = 20'hE0600;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_flags = 4'b0000;
    logic [1:0] cur_regsrc = 2'b00;
    logic [1:0] cur_immsrc = 2'b00;
    logic       imm_dc = 1'b0;

    function automatic obs_t observe();
        obs_t o;
        o.state     = bus.State;
        o.pcw       = bus.PCWrite;
        o.irw       = bus.IRWrite;
        o.regw      = bus.RegWrite;
        o.memw      = bus.MemWrite;
        o.adrsrc    = bus.AdrSrc;
        o.alusrca   = bus.ALUSrcA;
        o.alusrcb   = bus.ALUSrcB;
        o.resultsrc = bus.ResultSrc;
        o.aluctl    = bus.ALUControl;
        o.mov       = bus.MOVFlag;
        o.undef     = bus.Undef;
        o.flags     = bus.Flags;
        o.regsrc    = bus.RegSrc;
        o.immsrc    = bus.ImmSrc;
        return o;
    endfunction

    // Queue one cycle of stimulus and the outputs that cycle must show.
    task automatic push(input logic [19:0] instr, input logic [3:0] aluflags,
                        input logic [3:0] st, input logic pcw, input logic irw,
                        input logic regw, input logic memw, input logic undef,
                        input logic [2:0] aluctl, input logic mov);
        exp_t e;
        e.instr    = instr;
        e.aluflags = aluflags;
        e.v        = '0;
        e.v.state  = st;
        e.v.pcw    = pcw;
        e.v.irw    = irw;
        e.v.regw   = regw;
        e.v.memw   = memw;
        e.v.undef  = undef;
        e.v.aluctl = aluctl;
        e.v.mov    = mov;
        e.v.flags  = exp_flags;
        e.v.regsrc = cur_regsrc;
        e.v.immsrc = cur_immsrc;
        case (st)
            4'd0, 4'd1: begin e.v.alusrca = 1'b1; e.v.alusrcb = 2'b10; e.v.resultsrc = 2'b10; end
            4'd2:       e.v.alusrcb = 2'b01;
            4'd3:       e.v.adrsrc = 1'b1;
            4'd4:       e.v.resultsrc = 2'b01;
            4'd5:       e.v.adrsrc = 1'b1;
            4'd7:       e.v.alusrcb = 2'b01;
            4'd9:       begin e.v.alusrcb = 2'b01; e.v.resultsrc = 2'b10; end
            default:    ;
        endcase
        e.care = '1;
        if (imm_dc) e.care.immsrc = 2'b00;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        obs_t got;
        reset = 1'b1;
        bus.Instr = I_ADD;
        bus.ALUFlags = 4'b1111;
        @(negedge clk);
        #1 got = observe();
        checks++;
        if ({got.state, got.pcw, got.irw, got.regw, got.memw, got.undef, got.flags} !== 13'h0) begin
            errors++;
            $display("FAIL reset_enables got state=%0d en=%b%b%b%b undef=%b flags=%b want all 0",
                     got.state, got.pcw, got.irw, got.regw, got.memw, got.undef, got.flags);
        end
        checks++;
        if ({got.alusrca, got.alusrcb, got.resultsrc, got.adrsrc} !== 6'b1_10_10_0) begin
            errors++;
            $display("FAIL reset_fetch_muxes got %b%b%b%b want 110100",
                     got.alusrca, got.alusrcb, got.resultsrc, got.adrsrc);
        end
        @(posedge clk);
        #1 got = observe();
        checks++;
        if (got.state !== 4'd0 || got.pcw !== 1'b0 || got.irw !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got state=%0d pcw=%b irw=%b want 0 0 0", got.state, got.pcw, got.irw);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        exp_t e; obs_t got;
        cur_regsrc = 2'b00; cur_immsrc = 2'b00;
        push(I_ADD, 4'hF, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_ADD, 4'hF, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_ADD, 4'hF, 4'd6, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_ADD, 4'hF, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL add st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_subs_beq();
        exp_t e; obs_t got;
        cur_regsrc = 2'b00; cur_immsrc = 2'b00;
        push(I_SUBS, 4'b0110, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_SUBS, 4'b0110, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_SUBS, 4'b0110, 4'd7, 0, 0, 0, 0, 0, 3'b001, 0);
        exp_flags = 4'b0110;
        push(I_SUBS, 4'b0110, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        cur_regsrc = 2'b01; cur_immsrc = 2'b10;
        push(I_BEQ, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_BEQ, 4'b0000, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_BEQ, 4'b0000, 4'd9, 1, 0, 0, 0, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL subs_beq st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_ldr_str();
        exp_t e; obs_t got;
        cur_regsrc = 2'b00; cur_immsrc = 2'b01;
        push(I_LDR, 4'hF, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_LDR, 4'hF, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_LDR, 4'hF, 4'd2, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_LDR, 4'hF, 4'd3, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_LDR, 4'hF, 4'd4, 1, 0, 1, 0, 0, 3'b000, 0);
        cur_regsrc = 2'b10;
        push(I_STR, 4'hF, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_STR, 4'hF, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_STR, 4'hF, 4'd2, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_STR, 4'hF, 4'd5, 0, 0, 0, 1, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL ldr_str st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t got;
        cur_regsrc = 2'b00; cur_immsrc = 2'b00;
        // MOVS writes only N,Z; C,V keep 10 from the earlier SUBS.
        push(I_MOVS, 4'b1011, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_MOVS, 4'b1011, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_MOVS, 4'b1011, 4'd7, 0, 0, 0, 0, 0, 3'b000, 1);
        exp_flags = 4'b1010;
        push(I_MOVS, 4'b1011, 4'd8, 0, 0, 1, 0, 0, 3'b000, 0);
        push(I_CMP, 4'b0101, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_CMP, 4'b0101, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_CMP, 4'b0101, 4'd7, 0, 0, 0, 0, 0, 3'b001, 0);
        exp_flags = 4'b0101;
        push(I_CMP, 4'b0101, 4'd8, 0, 0, 0, 0, 0, 3'b000, 0);
        cur_regsrc = 2'b01; cur_immsrc = 2'b10;
        push(I_BNE, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_BNE, 4'b0000, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_BLT, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_BLT, 4'b0000, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_BLT, 4'b0000, 4'd9, 1, 0, 0, 0, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL back_to_back st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; obs_t got;
        cur_regsrc = 2'b00; cur_immsrc = 2'b01;
        push(I_LDR, 4'hF, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_LDR, 4'hF, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_LDR, 4'hF, 4'd2, 0, 0, 0, 0, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL reset_mid st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
        #1 got = observe();
        checks++;
        if (got.state !== 4'd3 || got.adrsrc !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_memread got state=%0d adrsrc=%b want 3 1", got.state, got.adrsrc);
        end
        #1 reset = 1'b1;
        #1 got = observe();
        checks++;
        if ({got.state, got.pcw, got.irw, got.regw, got.memw, got.undef, got.flags} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_async got state=%0d en=%b%b%b%b undef=%b flags=%b want all 0",
                     got.state, got.pcw, got.irw, got.regw, got.memw, got.undef, got.flags);
        end
        @(posedge clk);
        #1 got = observe();
        checks++;
        if (got.state !== 4'd0 || got.regw !== 1'b0 || got.pcw !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold got state=%0d regw=%b pcw=%b want 0 0 0", got.state, got.regw, got.pcw);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_flags = 4'b0000;
    endtask

    task automatic test_skip();
        exp_t e; obs_t got;
        cur_regsrc = 2'b01; cur_immsrc = 2'b10;
        push(I_BEQ, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_BEQ, 4'b0000, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        push(I_BEQ, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_BEQ, 4'b0000, 4'd1, 0, 0, 0, 0, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL skip st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_undef();
        exp_t e; obs_t got;
        cur_regsrc = 2'b00; cur_immsrc = 2'b00;
        imm_dc = 1'b1;
        push(I_UND, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_UND, 4'b0000, 4'd1, 0, 0, 0, 0, 1, 3'b000, 0);
        imm_dc = 1'b0;
        push(I_RSB, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        push(I_RSB, 4'b0000, 4'd1, 0, 0, 0, 0, 1, 3'b000, 0);
        push(I_ADD, 4'b0000, 4'd0, 1, 1, 0, 0, 0, 3'b000, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            bus.Instr = e.instr; bus.ALUFlags = e.aluflags;
            #1 got = observe();
            checks++;
            if (((got ^ e.v) & e.care) !== '0) begin
                errors++;
                $display("FAIL undef st%0d got=%h want=%h", e.v.state, got, e.v);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Instr    = I_ADD;
        bus.ALUFlags = 4'b0000;
        reset        = 1'b1;
        test_reset();
        test_add();
        test_subs_beq();
        test_ldr_str();
        test_back_to_back();
        test_reset_mid();
        test_skip();
        test_undef();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
